// File: rtl/powlib_pkg.sv
// Shared definitions for the powlib crossing helpers: FSM encodings and a
// constant-safe ceiling-log2 used to size id and counter fields.
package powlib_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/powlib_ffsync_sched_if.sv
// Requester-side bundle of the scheduler: level requests with payloads in,
// one-hot acks and the {id,payload} word plus strobe towards the ffsync out.
interface powlib_ffsync_sched_if #(
  parameter int W = 8,
  parameter int N = 4
) ();
  import powlib_pkg::*;

  localparam int IW = (N > 1) ? clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N*W-1:0]  data;
  logic [N-1:0]    ack;
  logic [IW+W-1:0] sync_d;
  logic            sync_vld;
  logic            busy;

  modport master (
    output req, data,
    input  ack, sync_d, sync_vld, busy
  );

  modport slave (
    input  req, data,
    output ack, sync_d, sync_vld, busy
  );

endinterface

// File: rtl/powlib_rrarb.sv
// Stateless round-robin pick: first set request at or above ptr, wrapping mod N.
// The pointer register belongs to the caller.
module powlib_rrarb
  import powlib_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gid
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    gid   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gid      = idx;
      end
    end
  end

endmodule

// File: rtl/powlib_ffsync_sched.sv
// Round-robin scheduler that time-multiplexes N requesters onto one ffsync
// crossing: launch {id,data} with a one-cycle strobe, then hold it HOLD cycles.
module powlib_ffsync_sched
  import powlib_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int HOLD = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  powlib_ffsync_sched_if.slave   bus
);

  localparam int IW = (N > 1) ? clog2(N) : 1;
  localparam int CW = (HOLD > 1) ? clog2(HOLD) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW+W-1:0] sync_d_q, sync_d_d;
  logic            sync_vld_q, sync_vld_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    gnt;
  logic [IW-1:0]   gid;
  logic [W-1:0]    words [N];

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = bus.data[i*W +: W];
  end

  powlib_rrarb #(.N(N), .IW(IW)) u_rrarb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (gnt),
    .gid (gid)
  );

  // Payload is captured only on the IDLE->LOAD edge so the far domain sees a
  // word that cannot change under it for the whole LOAD+HOLD window.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    sync_d_d   = sync_d_q;
    sync_vld_d = 1'b0;
    ack_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d    = S_LOAD;
          sync_d_d   = {gid, words[gid]};
          sync_vld_d = 1'b1;
          ack_d      = gnt;
          ptr_d      = (int'(gid) == N - 1) ? '0 : gid + 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_HOLD;
        cnt_d   = CW'(HOLD - 1);
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      sync_d_q   <= '0;
      sync_vld_q <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      sync_d_q   <= sync_d_d;
      sync_vld_q <= sync_vld_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.sync_d   = sync_d_q;
  assign bus.sync_vld = sync_vld_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_powlib_ffsync_sched.sv
// Directed bench for powlib_ffsync_sched (W=8, N=4, HOLD=6) with a launch
// scoreboard standing in for the far end of the ffsync crossing.
module tb_powlib_ffsync_sched;

  logic clk;
  logic rst;

  int check_cnt;
  int pass_cnt;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  powlib_ffsync_sched_if #(.W(8), .N(4)) bus ();

  powlib_ffsync_sched #(.W(8), .N(4), .HOLD(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every launch strobe is what the receiving ffsync would capture.
  always @(negedge clk) begin
    if (bus.sync_vld === 1'b1) obs_q.push_back(bus.sync_d);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_vld"},  32'(bus.sync_vld), 32'h0);
    checkOutput({tag, "_ack"},  32'(bus.ack),      32'h0);
    checkOutput({tag, "_d"},    32'(bus.sync_d),   32'h0);
    checkOutput({tag, "_busy"}, 32'(bus.busy),     32'h0);
  endtask

  // Waits (bounded) for the next launch strobe and checks ack, word and the
  // number of negedges elapsed since the call.
  task automatic applyStimulus(input string tag, input logic [3:0] exp_ack,
                               input logic [9:0] exp_d, input int exp_n);
    int n;
    n = 0;
    exp_q.push_back(exp_d);
    do begin
      step();
      n++;
    end while (bus.sync_vld !== 1'b1 && n < 20);
    checkOutput({tag, "_seen"}, 32'(bus.sync_vld), 32'h1);
    checkOutput({tag, "_ack"},  32'(bus.ack),      32'(exp_ack));
    checkOutput({tag, "_d"},    32'(bus.sync_d),   32'(exp_d));
    checkOutput({tag, "_lat"},  32'(n),            32'(exp_n));
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;

    // Test 1: reset with all requests held
    rst      = 1'b0;
    bus.req  = 4'b1111;
    bus.data = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    step();
    checkResetOutputs("rst1");
    rst = 1'b1;
    applyStimulus("t1", 4'b0001, 10'h011, 1);
    bus.req = 4'b0000;
    repeat (6) step();
    checkOutput("t1_busy_last", 32'(bus.busy), 32'h1);
    step();
    checkOutput("t1_idle", 32'(bus.busy), 32'h0);

    // Test 2: single requester 2, word stable and busy for seven cycles
    bus.req            = 4'b0100;
    bus.data[2*8 +: 8] = 8'hA5;
    applyStimulus("t2", 4'b0100, 10'h2A5, 1);
    bus.req = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("t2_hold_d",    32'(bus.sync_d),   32'h2A5);
      checkOutput("t2_hold_busy", 32'(bus.busy),     32'h1);
      checkOutput("t2_hold_vld",  32'(bus.sync_vld), 32'h0);
    end
    step();
    checkOutput("t2_idle", 32'(bus.busy), 32'h0);

    // Test 3: reset back to ptr=0, then continuous requests
    rst = 1'b0;
    #1;
    checkResetOutputs("rst3");
    bus.req = 4'b1111;
    step();
    rst = 1'b1;
    applyStimulus("t3_g0", 4'b0001, 10'h011, 1);
    applyStimulus("t3_g1", 4'b0010, 10'h122, 8);
    applyStimulus("t3_g2", 4'b0100, 10'h2A5, 8);
    applyStimulus("t3_g3", 4'b1000, 10'h344, 8);
    applyStimulus("t3_g4", 4'b0001, 10'h011, 8);

    // Test 4: ptr=1 with req 1001 -> grant 3 then 0
    bus.req = 4'b1001;
    applyStimulus("t4_g3", 4'b1000, 10'h344, 8);
    applyStimulus("t4_g0", 4'b0001, 10'h011, 8);

    // Test 5: data change and new request during HOLD
    bus.req = 4'b0000;
    step();
    bus.data[0*8 +: 8] = 8'hEE;
    bus.req            = 4'b0010;
    step();
    checkOutput("t5_d_frozen", 32'(bus.sync_d), 32'h011);
    checkOutput("t5_no_vld",   32'(bus.sync_vld), 32'h0);
    applyStimulus("t5_g1", 4'b0010, 10'h122, 6);

    // Test 6: async reset mid-HOLD (cnt=3), restart at ptr=0
    bus.req = 4'b0000;
    repeat (3) step();
    checkOutput("t6_busy_pre", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    #1;
    checkResetOutputs("rst6");
    bus.data[0*8 +: 8] = 8'h55;
    bus.req            = 4'b1111;
    step();
    rst = 1'b1;
    applyStimulus("t6_g0", 4'b0001, 10'h055, 1);
    bus.req = 4'b0000;
    repeat (8) step();
    checkOutput("t6_idle", 32'(bus.busy), 32'h0);

    // Scoreboard: every launched word seen exactly once, in order
    checkOutput("sb_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        checkOutput("sb_word", 32'(obs_q[i]), 32'(exp_q[i]));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
